// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
//
// Purpose: debounces a key press on the active-low rows, then walks a single low
// column across the matrix to locate the key. It reports the key code and pulses
// a strobe for the start/reset/ok function keys. Afterwards it waits for a
// debounced release before returning to IDLE.
//
// Optional macro: KEYPAD_DEBUG_VIEW_EN
//   defined   -> the *_view ports mirror the FSM state, debounce counter and scan index
//   undefined -> the *_view ports are tied to 0 (functional behaviour unchanged)
//
// Ports:
//   CLK                 in   system clock, rising edge
//   rst                 in   asynchronous active-low reset
//   row[3:0]            in   keypad rows, active-low
//   col[3:0]            out  column drive, active-low, registered
//   data[3:0]           out  code of last detected key (4*row + col)
//   start/reset/ok      out  one-cycle strobes for codes 10/11/12
//   idle                out  high while the FSM is in IDLE
//   state_view[4:0]     out  one-hot FSM state (debug)
//   anti_shake_cnt_view out  debounce counter (debug)
//   col_scan_cnt_view   out  column scan index (debug)

module keypad_scanner #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] data,
  output logic       start,
  output logic       reset,
  output logic       ok,
  output logic       idle,
  output logic [4:0] state_view,
  output logic [4:0] anti_shake_cnt_view,
  output logic [2:0] col_scan_cnt_view
);

  typedef enum logic [4:0] {
    IDLE        = 5'b00001,
    PRESS_CHECK = 5'b00010,
    SCAN        = 5'b00100,
    OUTPUT      = 5'b01000,
    FREE_CHECK  = 5'b10000
  } state_e;

  localparam logic [4:0] CNT_LAST = 5'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  state_e     state_q;
  logic [4:0] cnt_q;
  logic [2:0] k_q;
  logic [3:0] col_q;
  logic [3:0] data_q;
  logic       start_q;
  logic       reset_q;
  logic       ok_q;
  logic       idle_q;

  logic [1:0] hit_row_d;
  logic [3:0] code_d;
  logic [3:0] col_next_d;
  logic       any_row_low;

  assign any_row_low = (row != ROWS_IDLE);

  // Lowest row index wins when several keys share the driven column.
  always_comb begin
    hit_row_d = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row[r]) hit_row_d = 2'(r);
    end
  end

  assign code_d = {hit_row_d, k_q[1:0]};

  // Column pattern for the next scan step; col is registered, so it is loaded
  // one cycle ahead of the index it belongs to.
  always_comb begin
    col_next_d = 4'b1111;
    col_next_d[k_q[1:0] + 2'd1] = 1'b0;
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      k_q     <= 3'd0;
      col_q   <= 4'b0000;
      data_q  <= 4'd0;
      start_q <= 1'b0;
      reset_q <= 1'b0;
      ok_q    <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      start_q <= 1'b0;
      reset_q <= 1'b0;
      ok_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_row_low) begin
            state_q <= PRESS_CHECK;
            cnt_q   <= 5'd0;
            idle_q  <= 1'b0;
          end
        end
        PRESS_CHECK: begin
          if (!any_row_low) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            idle_q  <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= SCAN;
            cnt_q   <= 5'd0;
            k_q     <= 3'd0;
            col_q   <= 4'b1110;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        SCAN: begin
          if (any_row_low) begin
            state_q <= OUTPUT;
            col_q   <= 4'b0000;
            data_q  <= code_d;
            start_q <= (code_d == 4'd10);
            reset_q <= (code_d == 4'd11);
            ok_q    <= (code_d == 4'd12);
          end else if (k_q == 3'd3) begin
            // Every column tried without a hit: the press was spurious.
            state_q <= IDLE;
            k_q     <= k_q + 3'd1;
            col_q   <= 4'b0000;
            idle_q  <= 1'b1;
          end else begin
            k_q   <= k_q + 3'd1;
            col_q <= col_next_d;
          end
        end
        OUTPUT: begin
          state_q <= FREE_CHECK;
          cnt_q   <= 5'd0;
        end
        FREE_CHECK: begin
          if (any_row_low) begin
            cnt_q <= 5'd0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            idle_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 5'd0;
          k_q     <= 3'd0;
          col_q   <= 4'b0000;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign col   = col_q;
  assign data  = data_q;
  assign start = start_q;
  assign reset = reset_q;
  assign ok    = ok_q;
  assign idle  = idle_q;

`ifdef KEYPAD_DEBUG_VIEW_EN
  assign state_view          = state_q;
  assign anti_shake_cnt_view = cnt_q;
  assign col_scan_cnt_view   = k_q;
`else
  assign state_view          = 5'd0;
  assign anti_shake_cnt_view = 5'd0;
  assign col_scan_cnt_view   = 3'd0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a physical keypad model

module tb_keypad_scanner;

  localparam int D = 20;

`ifdef KEYPAD_DEBUG_VIEW_EN
  localparam int STATE_VIEW_RST = 1;
`else
  localparam int STATE_VIEW_RST = 0;
`endif

  logic       CLK = 1'b0;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] data;
  logic       start;
  logic       reset;
  logic       ok;
  logic       idle;
  logic [4:0] state_view;
  logic [4:0] anti_shake_cnt_view;
  logic [2:0] col_scan_cnt_view;

  keypad_scanner #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK(CLK), .rst(rst), .row(row), .col(col), .data(data),
    .start(start), .reset(reset), .ok(ok), .idle(idle),
    .state_view(state_view), .anti_shake_cnt_view(anti_shake_cnt_view),
    .col_scan_cnt_view(col_scan_cnt_view)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Keypad matrix: a pressed key (bit 4*r+c) pulls row r low whenever column c
  // is driven low and the contact is closed.
  logic [15:0] keys;
  logic        contact;
  always_comb begin
    row = 4'hF;
    if (contact) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
    end
  end

  typedef struct {int code; int due;} exp_t;
  exp_t q[$];
  exp_t e;
  int errors = 0;
  int checks = 0;
  int spurious = 0;
  int last_code = 0;
  logic [3:0] prev_col = 4'h0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the first column scanned that holds a pressed key wins, then the
  // lowest row inside that column.
  function automatic int expect_code(input logic [15:0] k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[4*r+c]) return 4*r + c;
    return -1;
  endfunction

  // Monitor: the OUTPUT cycle is the cycle where a scan column was driven and
  // the drive returns to all-low without the FSM dropping back to IDLE.
  always @(negedge CLK) begin
    if (!rst) begin
      prev_col = 4'h0;
    end else begin
      if (prev_col != 4'h0 && col == 4'h0 && !idle) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got code %0d expected none", data);
        end else begin
          e = q.pop_front();
          chk("code", int'(data), e.code);
          chk("latency_cycle", cyc, e.due);
          chk("start_strobe", int'(start), int'(e.code == 10));
          chk("reset_strobe", int'(reset), int'(e.code == 11));
          chk("ok_strobe", int'(ok), int'(e.code == 12));
        end
      end else if (start || reset || ok) begin
        spurious++;
      end
      prev_col = col;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Runs of closed contact shorter than the debounce window, separated by opens.
  task automatic bounce(input int pairs, input int max_open);
    for (int i = 0; i < pairs; i++) begin
      contact = 1'b1;
      hold($urandom_range(1, D - 1));
      contact = 1'b0;
      hold($urandom_range(1, max_open));
    end
  endtask

  task automatic press_release(input logic [15:0] k);
    int code;
    int rel;
    keys = k;
    bounce($urandom_range(0, 6), 4);
    code = expect_code(k);
    contact = 1'b1;
    // One edge for IDLE to notice, D debounce edges, then c+1 scan edges.
    q.push_back('{code: code, due: cyc + D + 2 + (code % 4)});
    last_code = code;
    hold(D + 8 + $urandom_range(0, 20));
    for (int i = $urandom_range(0, 4); i > 0; i--) begin
      contact = 1'b0;
      hold($urandom_range(1, D - 1));
      contact = 1'b1;
      hold($urandom_range(1, 3));
    end
    contact = 1'b0;
    rel = cyc;
    for (int i = 0; i < 4 * D && !idle; i++) @(negedge CLK);
    chk("release_to_idle_cycles", cyc - rel, D);
    chk("data_hold", int'(data), last_code);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_col"}, int'(col), 0);
    chk({tag, "_data"}, int'(data), 0);
    chk({tag, "_idle"}, int'(idle), 1);
    chk({tag, "_strobes"}, int'({start, reset, ok}), 0);
    chk({tag, "_state_view"}, int'(state_view), STATE_VIEW_RST);
    chk({tag, "_cnt_view"}, int'(anti_shake_cnt_view), 0);
    chk({tag, "_scan_view"}, int'(col_scan_cnt_view), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] k;
    int waited;
    rst = 1'b0;
    contact = 1'b0;
    keys = 16'h0;
    hold(3);
    chk_reset_state("reset");
    rst = 1'b1;
    hold(2);

    press_release(16'h1000);            // row 3, col 0 -> 12 (ok)
    press_release(16'h0100);            // row 2, col 0 -> 8
    press_release(16'h0001);            // row 0, col 0 -> 0
    press_release(16'h0400);            // row 2, col 2 -> 10 (start)
    press_release(16'h0800);            // row 2, col 3 -> 11 (reset)
    press_release(16'h8000);            // row 3, col 3 -> 15
    press_release(16'h2020);            // rows 1 and 3 in col 1 -> 5
    press_release(16'h0084);            // cols 2 and 3 -> 2

    for (int i = 0; i < 15; i++) begin
      k = 16'($urandom);
      if (k == 16'h0) k = 16'h0200;
      press_release(k);
    end

    // Short bounces only: must never reach a scan.
    keys = 16'h1000;
    bounce(10, 6);
    hold(D + 2);
    chk("bounce_idle", int'(idle), 1);
    chk("bounce_data_hold", int'(data), last_code);

    // Asynchronous reset in the middle of a scan.
    keys = 16'h8000;
    contact = 1'b1;
    waited = 0;
    while (col == 4'h0 && waited < 4 * D) begin
      @(negedge CLK);
      waited++;
    end
    chk("scan_reached", int'(col != 4'h0), 1);
    #2;
    rst = 1'b0;
    contact = 1'b0;
    #1;
    chk_reset_state("midscan_reset");
    last_code = 0;
    @(negedge CLK);
    rst = 1'b1;
    hold(2);

    press_release(16'h0010);            // row 1, col 0 -> 4 after recovery

    chk("no_spurious_strobes", spurious, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name:
keypad_scanner

Overview:
- 4x4 matrix-keypad scanner for the coin-charger front end.
- Debounces press and release, then scans columns to locate the key.
- Emits the key code, plus one-cycle strobes for the function keys start, reset and ok.
- Sits between the physical keypad pins and the charger control FSM.

Parameters:
DEBOUNCE_CYCLES, 20, number of consecutive stable cycles needed for press and release (legal range 2..31)

Ports:
CLK  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
row  input  4  keypad rows, active-low (bit r = 0 means row r pulled low)
col  output 4  keypad column drive, active-low, registered
data  output 4  code of last detected key, 0..15
start  output 1  one-cycle strobe, key code 10
reset  output 1  one-cycle strobe, key code 11
ok  output 1  one-cycle strobe, key code 12
idle  output 1  high while FSM is in IDLE
state_view  output 5  one-hot FSM state (debug)
anti_shake_cnt_view  output 5  debounce counter (debug)
col_scan_cnt_view  output 3  column scan index (debug)

Behaviour:
- Reset (rst=0, asynchronous) sets these values:
  - state=IDLE (5'b00001)
  - debounce counter=0, scan counter=0
  - col=4'b0000, data=0
  - start/reset/ok=0, idle=1
- FSM state encodings (one-hot):
  - IDLE=00001, PRESS_CHECK=00010, SCAN=00100, OUTPUT=01000, FREE_CHECK=10000
- Column drive by state:
  - IDLE, PRESS_CHECK, OUTPUT, FREE_CHECK: col=0000.
  - SCAN: scan index k drives col=1110, 1101, 1011, 0111 for k=0..3. Column c is low when k=c.
- IDLE:
  - row!=1111 -> PRESS_CHECK, counter=0.
  - Otherwise stay in IDLE.
- PRESS_CHECK:
  - row==1111 -> IDLE, counter cleared (bounce rejected).
  - Else counter increments.
  - When counter==DEBOUNCE_CYCLES-1 while row!=1111 -> SCAN, scan index=0, counter=0.
- SCAN, row sampled each cycle against the current col:
  - row!=1111: latch r = lowest index with row[r]=0, c = k. Go to OUTPUT.
  - Else k increments.
  - No hit after k=3 (k would reach 4) -> IDLE, treated as a spurious press.
- OUTPUT, exactly one cycle:
  - data <= 4*r + c.
  - Pulse start if code 10, reset if 11, ok if 12. Codes 13..15 update data with no strobe.
  - Then go to FREE_CHECK with counter=0.
- FREE_CHECK:
  - row==1111 increments counter; row!=1111 clears counter.
  - When counter==DEBOUNCE_CYCLES-1 with row==1111 -> IDLE.
- data holds its value until the next OUTPUT.
- Strobes are high only during the OUTPUT cycle.
- Latency from first stable press cycle to OUTPUT: DEBOUNCE_CYCLES + (c+1) cycles.
- Multiple keys in one column: lowest row index wins. Multiple columns: first column scanned wins.
- Counters saturate logic-free: thresholds are always reached before wrap, because DEBOUNCE_CYCLES ≤ 31.

Optional Feature:
KEYPAD_DEBUG_VIEW_EN
- Defined: state_view, anti_shake_cnt_view and col_scan_cnt_view mirror the internal state register, debounce counter and scan index.
- Undefined: all three ports exist but are tied to constant 0.
- Functional behaviour is identical in both cases.

Test Plan:
- Row 0111 alternating with 1111 every cycle for 15 pairs, then held 0111 for 60 cycles, then released with bounce.
  - FSM passes PRESS_CHECK→SCAN; hit at k=0.
  - Result: data=12, ok pulses exactly once; IDLE reached about 20 cycles after final release.
- Same stimulus with row 1011 held.
  - Result: data=8, no strobe.
- Row 1011 driven only while state is PRESS_CHECK or OUTPUT, or SCAN with col=1110; else 1111.
  - Result: data=8; FREE_CHECK returns to IDLE after 20 idle cycles.
- Same column-gated stimulus with row 1110.
  - Result: data=0, no strobes.
- Bounce with runs of fewer than 20 cycles low.
  - Result: never leaves PRESS_CHECK/IDLE; data unchanged; no strobes.
- Assert rst=0 mid-SCAN.
  - Result: immediately state=00001, col=0000, idle=1, counters 0.
